// File: rtl/ray_prim_sequencer.sv
// Ray/primitive batch sequencer: fetches a primitive range, feeds WIDTH-lane batches to a hit unit, reduces hits.
// Optional stats counters are enabled with `define RAY_PRIM_SEQUENCER_STATS_EN.
`ifndef AABB_TEST_UNIT_SIZE
`define AABB_TEST_UNIT_SIZE 4
`endif

package ray_prim_pkg;
  // Fixed point values are signed Q16.16.
  typedef struct packed {
    logic [2:0][31:0] origin;
    logic [2:0][31:0] dir;
  } Ray;

  typedef struct packed {
    logic [15:0]      pi;
    logic [2:0][31:0] lo;
    logic [2:0][31:0] hi;
  } BVH_Primitive_AABB;

  typedef struct packed {
    logic        bHit;
    logic [31:0] T;
    logic [15:0] PI;
  } HitData;

  function automatic logic [31:0] FixedInf();
    return 32'h7FFF_FFFF;
  endfunction
endpackage

module ray_prim_lane
  import ray_prim_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr,
  input  logic              dup,
  input  BVH_Primitive_AABB wdata,
  input  BVH_Primitive_AABB dup_data,
  output BVH_Primitive_AABB q
);
  always_ff @(posedge clk) begin
    if (resetn)   q <= '0;
    else if (wr)  q <= wdata;
    else if (dup) q <= dup_data;
  end
endmodule

module ray_prim_sequencer
  import ray_prim_pkg::*;
#(
  parameter int WIDTH = `AABB_TEST_UNIT_SIZE,
  parameter int IDX_W = 16
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  Ray                                  req_ray,
  input  logic [IDX_W-1:0]                    req_start,
  input  logic [IDX_W-1:0]                    req_count,
  input  logic                                req_any,
  output logic                                prim_rd_valid,
  input  logic                                prim_rd_ready,
  output logic [IDX_W-1:0]                    prim_rd_addr,
  input  logic                                prim_rsp_valid,
  input  BVH_Primitive_AABB                   prim_rsp_data,
  output logic                                unit_valid,
  output Ray                                  unit_ray,
  output BVH_Primitive_AABB [WIDTH-1:0]       unit_prim,
  input  HitData                              unit_hit,
  input  logic                                unit_any,
  output logic                                res_valid,
  input  logic                                res_ready,
  output HitData                              res_hit,
  output logic [31:0]                         stat_batches,
  output logic [31:0]                         stat_prims
);
  localparam int LW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam HitData ACC_INIT = '{bHit: 1'b0, T: 32'h7FFF_FFFF, PI: 16'h0};

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  start_q, count_q, fetched;
  logic              any_q, outstanding;
  logic [LW-1:0]     lane_idx;
  HitData            acc;

  logic              rsp_fire, batch_end, closer, more;
  BVH_Primitive_AABB lane0_data;

  // Responses only count while a read is actually in flight.
  assign rsp_fire   = (state == FETCH) && outstanding && prim_rsp_valid;
  assign batch_end  = rsp_fire && ((lane_idx == LW'(WIDTH-1)) ||
                                   (IDX_W'(fetched + 1'b1) == count_q));
  assign lane0_data = (lane_idx == '0) ? prim_rsp_data : unit_prim[0];
  assign closer     = unit_hit.bHit &&
                      (!acc.bHit || ($signed(unit_hit.T) < $signed(acc.T)));
  assign more       = (fetched != count_q);
  assign res_hit    = acc;

  // Unfilled lanes of a short batch copy lane 0 so they cannot change the result.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ray_prim_lane u_lane (
      .clk      (clk),
      .resetn   (resetn),
      .wr       (rsp_fire && (int'(lane_idx) == i)),
      .dup      (batch_end && (int'(lane_idx) < i)),
      .wdata    (prim_rsp_data),
      .dup_data (lane0_data),
      .q        (unit_prim[i])
    );
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      prim_rd_valid <= 1'b0;
      prim_rd_addr  <= '0;
      unit_valid    <= 1'b0;
      unit_ray      <= '0;
      res_valid     <= 1'b0;
      acc           <= ACC_INIT;
      start_q       <= '0;
      count_q       <= '0;
      fetched       <= '0;
      any_q         <= 1'b0;
      outstanding   <= 1'b0;
      lane_idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready   <= 1'b0;
            unit_ray    <= req_ray;
            start_q     <= req_start;
            count_q     <= req_count;
            any_q       <= req_any;
            acc         <= ACC_INIT;
            fetched     <= '0;
            lane_idx    <= '0;
            outstanding <= 1'b0;
            if (req_count != '0) begin
              state         <= FETCH;
              prim_rd_valid <= 1'b1;
              prim_rd_addr  <= req_start;
            end else begin
              state     <= DONE;
              res_valid <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (prim_rd_valid && prim_rd_ready) begin
            prim_rd_valid <= 1'b0;
            outstanding   <= 1'b1;
          end
          if (rsp_fire) begin
            outstanding <= 1'b0;
            fetched     <= fetched + 1'b1;
            if (batch_end) begin
              lane_idx   <= '0;
              unit_valid <= 1'b1;
              state      <= EVAL;
            end else begin
              lane_idx      <= lane_idx + 1'b1;
              prim_rd_valid <= 1'b1;
              prim_rd_addr  <= start_q + fetched + 1'b1;
            end
          end
        end
        EVAL: begin
          unit_valid <= 1'b0;
          if (!any_q && closer) acc <= unit_hit;
          if (any_q && unit_any) begin
            acc.bHit  <= 1'b1;
            state     <= DONE;
            res_valid <= 1'b1;
          end else if (more) begin
            state         <= FETCH;
            prim_rd_valid <= 1'b1;
            prim_rd_addr  <= start_q + fetched;
          end else begin
            state     <= DONE;
            res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAY_PRIM_SEQUENCER_STATS_EN
  always_ff @(posedge clk) begin
    if (resetn) begin
      stat_batches <= '0;
      stat_prims   <= '0;
    end else begin
      if (unit_valid && (stat_batches != '1)) stat_batches <= stat_batches + 1'b1;
      if (rsp_fire && (stat_prims != '1))     stat_prims   <= stat_prims + 1'b1;
    end
  end
`else
  assign stat_batches = '0;
  assign stat_prims   = '0;
`endif

endmodule

// File: tb/tb_ray_prim_sequencer.sv
// Scoreboard bench for ray_prim_sequencer with a small memory model and a behavioural hit unit.
module tb_ray_prim_sequencer;
  import ray_prim_pkg::*;

  localparam int WIDTH = 4;
  localparam int IDX_W = 16;
  localparam logic [31:0] INF = 32'h7FFF_FFFF;

  logic clk, resetn;
  logic req_valid, req_ready, req_any;
  Ray   req_ray;
  logic [IDX_W-1:0] req_start, req_count;
  logic prim_rd_valid, prim_rd_ready;
  logic [IDX_W-1:0] prim_rd_addr;
  logic prim_rsp_valid;
  BVH_Primitive_AABB prim_rsp_data;
  logic unit_valid;
  Ray   unit_ray;
  BVH_Primitive_AABB [WIDTH-1:0] unit_prim;
  HitData unit_hit;
  logic unit_any;
  logic res_valid, res_ready;
  HitData res_hit;
  logic [31:0] stat_batches, stat_prims;

  typedef struct {
    logic        bhit;
    logic [31:0] t;
    logic [15:0] pi;
    bit          cmp_t;
    bit          cmp_pi;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  logic [31:0] hit_map[int];
  int          vectors = 0, miscompares = 0, eval_seen = 0, rd_seen = 0;
  bit          glitch = 0;
  logic [31:0] cur_tag = 0;

  ray_prim_sequencer #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_ray(req_ray),
    .req_start(req_start), .req_count(req_count), .req_any(req_any),
    .prim_rd_valid(prim_rd_valid), .prim_rd_ready(prim_rd_ready), .prim_rd_addr(prim_rd_addr),
    .prim_rsp_valid(prim_rsp_valid), .prim_rsp_data(prim_rsp_data),
    .unit_valid(unit_valid), .unit_ray(unit_ray), .unit_prim(unit_prim),
    .unit_hit(unit_hit), .unit_any(unit_any),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .stat_batches(stat_batches), .stat_prims(stat_prims)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic BVH_Primitive_AABB prim_at(input logic [15:0] a);
    BVH_Primitive_AABB p;
    p = '0;
    p.pi = a;
    if (hit_map.exists(int'(a))) begin
      p.lo[0][0] = 1'b1;
      p.hi[0]    = hit_map[int'(a)];
    end
    return p;
  endfunction

  // Hit unit: lane hits if lo[0][0] set, distance in hi[0]; lowest lane wins ties.
  always_comb begin
    unit_hit   = '0;
    unit_hit.T = INF;
    unit_any   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (unit_prim[i].lo[0][0]) begin
        unit_any = 1'b1;
        if (!unit_hit.bHit || $signed(unit_prim[i].hi[0]) < $signed(unit_hit.T)) begin
          unit_hit.bHit = 1'b1;
          unit_hit.T    = unit_prim[i].hi[0];
          unit_hit.PI   = unit_prim[i].pi;
        end
      end
    end
  end

  // Single-cycle memory; optionally injects a stray response right after each EVAL.
  always @(posedge clk) begin
    if (resetn) prim_rsp_valid <= 1'b0;
    else begin
      prim_rsp_valid <= 1'b0;
      if (prim_rd_valid && prim_rd_ready) begin
        prim_rsp_valid <= 1'b1;
        prim_rsp_data  <= prim_at(prim_rd_addr);
      end else if (glitch && unit_valid) begin
        prim_rsp_valid <= 1'b1;
        prim_rsp_data  <= '{pi: 16'hDEAD, lo: 96'h1, hi: 96'h0};
      end
    end
  end

  // Monitor: checks reads and results against the queued expectations.
  always @(negedge clk) begin
    if (!resetn) begin
      if (unit_valid) begin
        eval_seen++;
        chk("unit_ray", {32'h0, unit_ray.origin[0]}, {32'h0, cur_tag});
      end
      if (prim_rd_valid && prim_rd_ready) begin
        rd_seen++;
        if (addr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rd_unexpected: got addr 0x%0h, want no read", prim_rd_addr);
        end else chk("rd_addr", {48'h0, prim_rd_addr}, {48'h0, addr_q.pop_front()});
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL res_unexpected: got bHit %0d T 0x%0h, want no result", res_hit.bHit, res_hit.T);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("res_bhit", {63'h0, res_hit.bHit}, {63'h0, e.bhit});
          if (e.cmp_t)  chk("res_t",  {32'h0, res_hit.T},  {32'h0, e.t});
          if (e.cmp_pi) chk("res_pi", {48'h0, res_hit.PI}, {48'h0, e.pi});
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    chk("req_ready_wait", {63'h0, req_ready}, 64'h1);
  endtask

  task automatic issue(input logic [15:0] start, input logic [15:0] cnt, input bit any);
    wait_ready();
    cur_tag   = {16'h5A5A, start};
    req_ray   = '0;
    req_ray.origin[0] = cur_tag;
    req_start = start;
    req_count = cnt;
    req_any   = any;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_req(input logic [15:0] start, input logic [15:0] cnt, input bit any,
                         input exp_t e, input int n_reads, input int n_evals);
    int e0, r0, n;
    logic [15:0] a;
    exp_q.push_back(e);
    for (int i = 0; i < n_reads; i++) begin
      a = start + 16'(i);
      addr_q.push_back(a);
    end
    e0 = eval_seen;
    r0 = rd_seen;
    issue(start, cnt, any);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 400);
    chk("latency", 64'(n), 64'(n_evals + 2 * n_reads + 1));
    @(posedge clk);
    #1;
    chk("evals", 64'(eval_seen - e0), 64'(n_evals));
    chk("reads", 64'(rd_seen - r0), 64'(n_reads));
    chk("pending_reads", 64'(addr_q.size()), 64'h0);
    chk("pending_results", 64'(exp_q.size()), 64'h0);
    addr_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {63'h0, req_ready}, 64'h0);
    chk({tag, "_rd_valid"},  {63'h0, prim_rd_valid}, 64'h0);
    chk({tag, "_unit_valid"},{63'h0, unit_valid}, 64'h0);
    chk({tag, "_res_valid"}, {63'h0, res_valid}, 64'h0);
    chk({tag, "_bhit"},      {63'h0, res_hit.bHit}, 64'h0);
    chk({tag, "_t"},         {32'h0, res_hit.T}, {32'h0, INF});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b1;
    req_valid = 1'b0; req_ray = '0; req_start = '0; req_count = '0; req_any = 1'b0;
    prim_rd_ready = 1'b1;
    res_ready = 1'b1;
    prim_rsp_data = '0;

    hit_map[11]     = 32'h0005_0000;
    hit_map[14]     = 32'h0003_0000;
    hit_map[101]    = 32'h0002_0000;
    hit_map[105]    = 32'h0002_0000;
    hit_map[201]    = 32'h0001_0000;
    hit_map[403]    = 32'h0001_0000;
    hit_map[601]    = 32'h000C_0000;
    hit_map[604]    = 32'h0009_0000;
    hit_map[0]      = 32'h0006_0000;
    hit_map[32'h1003] = 32'h0001_0000;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    resetn = 1'b0;

    // count = 0: immediate miss, no reads
    run_req(16'd5, 16'd0, 1'b0, '{1'b0, INF, 16'h0, 1'b1, 1'b0}, 0, 0);
    // two batches, closest at index 14, with stray responses after each EVAL
    glitch = 1;
    run_req(16'd10, 16'd6, 1'b0, '{1'b1, 32'h0003_0000, 16'd14, 1'b1, 1'b1}, 6, 2);
    glitch = 0;
    // equal T across batches keeps the earlier batch
    run_req(16'd100, 16'd8, 1'b0, '{1'b1, 32'h0002_0000, 16'd101, 1'b1, 1'b1}, 8, 2);
    // any-hit early exit on the first batch
    run_req(16'd200, 16'd12, 1'b1, '{1'b1, 32'h0, 16'h0, 1'b0, 1'b0}, 4, 1);
    // any-hit with no hits at all
    run_req(16'd700, 16'd3, 1'b1, '{1'b0, 32'h0, 16'h0, 1'b0, 1'b0}, 3, 1);
    // leave a hit in lane 3, then a one-prim batch must not see it
    run_req(16'd400, 16'd4, 1'b0, '{1'b1, 32'h0001_0000, 16'd403, 1'b1, 1'b1}, 4, 1);
    run_req(16'd500, 16'd1, 1'b0, '{1'b0, INF, 16'h0, 1'b1, 1'b0}, 1, 1);
    // partial final batch holds the closer hit
    run_req(16'd600, 16'd5, 1'b0, '{1'b1, 32'h0009_0000, 16'd604, 1'b1, 1'b1}, 5, 2);

    // reset pulsed mid-FETCH: two reads issued, then everything abandoned
    begin
      int r0;
      r0 = rd_seen;
      addr_q.push_back(16'h1000);
      addr_q.push_back(16'h1001);
      issue(16'h1000, 16'd8, 1'b0);
      repeat (4) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk_reset_outputs("midreset");
      chk("midreset_reads", 64'(rd_seen - r0), 64'd2);
      chk("midreset_pending", 64'(addr_q.size()), 64'h0);
      addr_q.delete();
      resetn = 1'b0;
    end

    // address wrap at 2^IDX_W
    run_req(16'hFFFE, 16'd3, 1'b0, '{1'b1, 32'h0006_0000, 16'h0000, 1'b1, 1'b1}, 3, 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ray_prim_sequencer.md
RAY_PRIM_SEQUENCER -- requirements
Module: ray_prim_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default `AABB_TEST_UNIT_SIZE, primitive lanes per batch presented to the hit unit.
REQ-002 SHALL have parameter IDX_W, default 16, width of primitive index and count.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 resetn  in  1  reset; synchronous and active-high despite its name.
REQ-005 req_valid/req_ready  in/out  1/1  request handshake; transfer when both high.
REQ-006 req_ray  in  Ray  ray to test; req_start, req_count  in  IDX_W  primitive range; req_any  in  1  any-hit mode.
REQ-007 prim_rd_valid/prim_rd_ready  out/in  1/1  primitive read request handshake; prim_rd_addr  out  IDX_W.
REQ-008 prim_rsp_valid  in  1, prim_rsp_data  in  BVH_Primitive_AABB  read response; no backpressure.
REQ-009 unit_valid  out  1; unit_ray  out  Ray; unit_prim  out  BVH_Primitive_AABB[WIDTH]  batch to combinational hit unit.
REQ-010 unit_hit  in  HitData (closest-hit result); unit_any  in  1 (any-hit result); both valid in the cycle unit_valid is high.
REQ-011 res_valid/res_ready  out/in  1/1  result handshake; res_hit  out  HitData.

Function
REQ-012 SHALL implement states IDLE, FETCH, EVAL, DONE.
REQ-013 IDLE: req_ready=1; on request transfer latch ray, start, count, any; set acc.bHit=0, acc.T=FixedInf(); go FETCH if count>0, else DONE.
REQ-014 FETCH: at most one read outstanding; prim_rd_addr = start+fetched, modulo 2^IDX_W; each response written to lane (fetched mod WIDTH).
REQ-015 FETCH -> EVAL when WIDTH lanes are filled or all count primitives have been received.
REQ-016 Partial final batch: empty lanes SHALL duplicate lane 0 of that batch, so the batch result is unchanged.
REQ-017 EVAL: unit_valid=1 for exactly one cycle; unit_prim and unit_ray registered and stable for that cycle.
REQ-018 Closest mode: replace acc with unit_hit iff unit_hit.bHit && (!acc.bHit || unit_hit.T < acc.T); on a tie the earlier batch is kept.
REQ-019 Any mode: if unit_any=1, set acc.bHit=1 and go DONE immediately, skipping remaining primitives; acc.T is unspecified.
REQ-020 After EVAL: go FETCH if primitives remain, else DONE.
REQ-021 DONE: res_valid=1, res_hit=acc held stable until res_ready; on transfer go IDLE.
REQ-022 req_ready SHALL be 0 in all states other than IDLE.
REQ-023 prim_rsp_valid SHALL be ignored when no read is outstanding.
REQ-024 Latency with single-cycle memory and res_ready=1: ceil(count/WIDTH) EVAL cycles + count*2 FETCH cycles + 2.

Reset
REQ-025 While resetn=1: state=IDLE, req_ready=0, prim_rd_valid=0, unit_valid=0, res_valid=0, acc.bHit=0, acc.T=FixedInf(), counters=0.
REQ-026 Reset mid-operation SHALL abandon the request silently; the memory side is reset by the same resetn.

Configuration
REQ-027 With RAY_PRIM_SEQUENCER_STATS_EN defined: outputs stat_batches and stat_prims (32 bits each, saturating) count EVAL cycles and received primitives since reset.
REQ-028 Without RAY_PRIM_SEQUENCER_STATS_EN: the ports SHALL exist and be tied to 0; no counter logic is present.

Verification
REQ-029 count=0, res_ready=1 -> res_valid within 2 cycles, bHit=0, T=FixedInf(), no reads issued.
REQ-030 WIDTH=4, count=6, start=10, hits with T=5.0 at index 11 and T=3.0 at index 14 -> two EVAL cycles, reads 10..15, result T=3.0.
REQ-031 Tie: equal T=2.0 in batch 0 and batch 1 -> result is the batch-0 hit (its PI).
REQ-032 Any mode, count=12, WIDTH=4, unit_any=1 on the first batch -> exactly 4 reads, 1 EVAL cycle, bHit=1.
REQ-033 start=0xFFFE, count=3 -> addresses 0xFFFE, 0xFFFF, 0x0000; resetn pulsed during FETCH -> IDLE with all outputs at reset values the next cycle.
